// File: rtl/count_tick_ctrl_pkg.sv
// Shared constants for the count tick control front end.
//   DEF_DIV        default clk cycles per tick period
//   DEF_DB_CYCLES  default debounce stability window
//   SYNC_STAGES    depth of the input synchronisers
//   clog2()        counter width able to hold 0..n-1 (never less than 1 bit)
package count_pkg;

  localparam int DEF_DIV       = 10_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;
  localparam int SYNC_STAGES   = 2;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++)
      if ((longint'(1) << i) < longint'(n)) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/count_tick_ctrl_if.sv
// Board-side bundle of count_tick_ctrl.
//   SW, BTN_pause, BTN_step : raw switch / push-buttons into the block
//   tick, dir, paused       : controls towards the counter stage
// slave modport is the block's view, master is the driver's view.
interface count_tick_ctrl_if;
  logic SW;
  logic BTN_pause;
  logic BTN_step;
  logic tick;
  logic dir;
  logic paused;

  modport master (output SW, BTN_pause, BTN_step, input tick, dir, paused);
  modport slave  (input SW, BTN_pause, BTN_step, output tick, dir, paused);
endinterface

// File: rtl/count_tick_ctrl_debounce.sv
// debounce: SYNC_STAGES-FF synchroniser followed by a stability filter and
// rise detector for one raw board input.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   level      : debounced level, flips after DB_CYCLES consecutive
//                synchronised samples that differ from it
//   rise       : one-cycle pulse on the cycle level is 1 after being 0
module debounce
  import count_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = clog2(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   level_prev;
  logic                   s_in;

  assign s_in = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], din};
      level_prev <= level;
      // Any sample agreeing with the held level restarts the window, so
      // bounces shorter than DB_CYCLES never reach the flip.
      if (s_in == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_prev;

endmodule

// File: rtl/count_tick_ctrl.sv
// count_tick_ctrl: count-enable tick generator and direction register for
// the reversible counter stage.
//   clk    : system clock
//   RST_n  : asynchronous active-low reset
//   io     : slave side of count_tick_ctrl_if
//            SW (1 = up), BTN_pause (toggles run/pause), BTN_step
//            tick (one-cycle enable, every DIV cycles while running)
//            dir (debounced SW, frozen across each tick), paused
// Build option: define STEP_EN to make debounced BTN_step rises issue a
// single tick while paused. Without it BTN_step is ignored and its
// debouncer is not built.
module count_tick_ctrl
  import count_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input logic              clk,
  input logic              RST_n,
  count_tick_ctrl_if.slave io
);

  localparam int PW = clog2(DIV);

  logic [PW-1:0] pre;
  logic          tick_q, dir_q, paused_q;
  logic          sw_lvl, pause_rise, step_go;
  logic          wrap, run, tick_d;
  logic          unused_sw_rise, unused_pause_lvl;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw (
    .clk   (clk),
    .rst_n (RST_n),
    .din   (io.SW),
    .level (sw_lvl),
    .rise  (unused_sw_rise)
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk   (clk),
    .rst_n (RST_n),
    .din   (io.BTN_pause),
    .level (unused_pause_lvl),
    .rise  (pause_rise)
  );

`ifdef STEP_EN
  logic step_rise, unused_step_lvl;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk   (clk),
    .rst_n (RST_n),
    .din   (io.BTN_step),
    .level (unused_step_lvl),
    .rise  (step_rise)
  );

  // A pause edge in the same cycle wins over the step.
  assign step_go = step_rise & paused_q & ~pause_rise;
`else
  logic unused_step;
  assign unused_step = io.BTN_step;
  assign step_go     = 1'b0;
`endif

  assign wrap = (pre == PW'(DIV - 1));
  // A pause edge freezes the prescaler in its own cycle, so a pause landing
  // on the wrap keeps pre at DIV-1 and the tick fires on the first run
  // cycle after resume.
  assign run    = ~paused_q & ~pause_rise;
  assign tick_d = (run & wrap) | step_go;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      pre      <= '0;
      tick_q   <= 1'b0;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_q ^ pause_rise;
      if (run) pre <= wrap ? '0 : pre + PW'(1);
      tick_q <= tick_d;
      // Holding dir on the tick-load edge keeps it constant before, during
      // and after every tick.
      if (!tick_d) dir_q <= sw_lvl;
    end
  end

  assign io.tick   = tick_q;
  assign io.dir    = dir_q;
  assign io.paused = paused_q;

endmodule

// File: tb/tb_count_tick_ctrl.sv
// Bench for count_tick_ctrl with DIV=10, DB_CYCLES=4: hand-derived
// sequences, a vector table, and randomized stimulus checked every cycle
// against a behavioural reference model.
module tb_count_tick_ctrl;

  localparam int DIV = 10;
  localparam int DB  = 4;
`ifdef STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic RST_n;

  count_tick_ctrl_if io();

  count_tick_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .RST_n (RST_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ticks_seen = 0;

  // Reference model: inputs 0=SW 1=BTN_pause 2=BTN_step.
  int m_sync[3][2];
  int m_lvl[3], m_prev[3], m_diff[3];
  int m_runs;   // run cycles since reset; prescaler = m_runs % DIV
  int m_tick, m_dir, m_paused;

  typedef struct {
    bit    sw;
    bit    pause;
    int    cycles;
    int    exp_ticks;
    bit    exp_dir;
    bit    exp_paused;
    string name;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sync[i][0] = 0; m_sync[i][1] = 0;
      m_lvl[i] = 0; m_prev[i] = 0; m_diff[i] = 0;
    end
    m_runs = 0; m_tick = 0; m_dir = 0; m_paused = 0;
  endfunction

  function automatic void model_step();
    int  raw[3];
    int  rp, rs, nt;
    bit  running;
    raw[0] = int'(io.SW); raw[1] = int'(io.BTN_pause); raw[2] = int'(io.BTN_step);
    rp = (m_lvl[1] == 1 && m_prev[1] == 0) ? 1 : 0;
    rs = (STEP_ON && m_lvl[2] == 1 && m_prev[2] == 0) ? 1 : 0;
    running = (m_paused == 0) && (rp == 0);
    nt = ((running && (m_runs % DIV) == DIV - 1) ||
          (m_paused == 1 && rs == 1 && rp == 0)) ? 1 : 0;
    if (nt == 0) m_dir = m_lvl[0];
    m_tick = nt;
    if (rp == 1) m_paused = 1 - m_paused;
    if (running) m_runs++;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = m_lvl[i];
      if (m_sync[i][1] == m_lvl[i]) m_diff[i] = 0;
      else begin
        m_diff[i]++;
        if (m_diff[i] == DB) begin m_lvl[i] = 1 - m_lvl[i]; m_diff[i] = 0; end
      end
      m_sync[i][1] = m_sync[i][0];
      m_sync[i][0] = raw[i];
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (RST_n) model_step(); else model_reset();
    @(negedge clk);
    chk("model_tick", int'(io.tick), m_tick);
    chk("model_dir", int'(io.dir), m_dir);
    chk("model_paused", int'(io.paused), m_paused);
    if (io.tick) ticks_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin cyc(); k++; end while (!io.tick && k < 40);
    chk("wait_tick", int'(io.tick), 1);
  endtask

  // Reset released at the preceding negedge: tick is seen after posedge 10
  // (the 11th cycle counting the release cycle), then every 10.
  task automatic run_cadence(input string tag);
    int first, prev;
    first = -1; prev = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (io.tick) begin
        if (first < 0) first = k;
        else chk({tag, "_period"}, k - prev, DIV);
        prev = k;
      end
    end
    chk({tag, "_first_tick"}, first, 10);
  endtask

  initial begin
    int dir_hi, lat, tick7, pj, rj, tj, w_left;
    bit lvl;

    tbl[0] = '{sw:1'b1, pause:1'b0, cycles:20, exp_ticks:2, exp_dir:1'b1, exp_paused:1'b0, name:"r1_sw_up"};
    tbl[1] = '{sw:1'b1, pause:1'b1, cycles:10, exp_ticks:0, exp_dir:1'b1, exp_paused:1'b1, name:"r2_pause"};
    tbl[2] = '{sw:1'b1, pause:1'b0, cycles:20, exp_ticks:0, exp_dir:1'b1, exp_paused:1'b1, name:"r3_release"};
    tbl[3] = '{sw:1'b0, pause:1'b1, cycles:20, exp_ticks:1, exp_dir:1'b0, exp_paused:1'b0, name:"r4_resume"};

    RST_n = 1'b0; io.SW = 1'b0; io.BTN_pause = 1'b0; io.BTN_step = 1'b0;
    model_reset();
    hold(3);
    chk("reset_tick", int'(io.tick), 0);
    chk("reset_dir", int'(io.dir), 0);
    chk("reset_paused", int'(io.paused), 0);

    // 1: reset release, no activity
    RST_n = 1'b1;
    run_cadence("t1");
    chk("t1_dir", int'(io.dir), 0);
    chk("t1_paused", int'(io.paused), 0);

    // Vector table continues from prescaler 0 after the tick at cycle 30.
    for (int i = 0; i < 4; i++) begin
      io.SW = tbl[i].sw; io.BTN_pause = tbl[i].pause;
      ticks_seen = 0;
      hold(tbl[i].cycles);
      chk({tbl[i].name, "_ticks"}, ticks_seen, tbl[i].exp_ticks);
      chk({tbl[i].name, "_dir"}, int'(io.dir), int'(tbl[i].exp_dir));
      chk({tbl[i].name, "_paused"}, int'(io.paused), int'(tbl[i].exp_paused));
    end

    // 2: bounce then settle
    io.BTN_pause = 1'b0;
    dir_hi = 0; w_left = 0; lvl = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (w_left == 0) begin lvl = ~lvl; w_left = $urandom_range(1, 3); end
      io.SW = lvl; w_left--;
      cyc();
      if (io.dir) dir_hi++;
    end
    io.SW = 1'b0;
    for (int c = 0; c < 6; c++) begin cyc(); if (io.dir) dir_hi++; end
    chk("t2_bounce_dir", dir_hi, 0);
    io.SW = 1'b1; lat = -1; tick7 = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 7) tick7 = int'(io.tick);
      if (io.dir && lat < 0) lat = k;
    end
    chk("t2_dir_latency", lat, (tick7 != 0) ? 8 : 7);

    // 3: pause lands with prescaler at 3, resume after 10-3 cycles
    wait_tick();
    hold(7);
    io.BTN_pause = 1'b1; pj = -1; ticks_seen = 0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 7) io.BTN_pause = 1'b0;
      cyc();
      if (io.paused && pj < 0) pj = j;
    end
    chk("t3_pause_latency", pj, 7);
    chk("t3_ticks_before_pause", ticks_seen, 1);
    ticks_seen = 0;
    hold(20);
    chk("t3_ticks_while_paused", ticks_seen, 0);
    io.BTN_pause = 1'b1; rj = -1; tj = -1;
    for (int j = 1; j <= 30; j++) begin
      if (j == 7) io.BTN_pause = 1'b0;
      cyc();
      if (!io.paused && rj < 0) rj = j;
      if (io.tick && tj < 0) tj = j;
    end
    chk("t3_resume_latency", rj, 7);
    chk("t3_resume_to_tick", tj - rj, 7);

    // 4: pause edge on prescaler wrap
    wait_tick();
    hold(3);
    io.BTN_pause = 1'b1; pj = -1; ticks_seen = 0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 7) io.BTN_pause = 1'b0;
      cyc();
      if (io.paused && pj < 0) pj = j;
    end
    chk("t4_pause_latency", pj, 7);
    chk("t4_no_tick", ticks_seen, 0);
    hold(10);
    io.BTN_pause = 1'b1; rj = -1; tj = -1;
    for (int j = 1; j <= 20; j++) begin
      if (j == 7) io.BTN_pause = 1'b0;
      cyc();
      if (!io.paused && rj < 0) rj = j;
      if (io.tick && tj < 0) tj = j;
    end
    chk("t4_resume_tick", tj - rj, 1);

    // 5: single step
    io.BTN_pause = 1'b1; hold(6); io.BTN_pause = 1'b0; hold(8);
    chk("t5_paused", int'(io.paused), 1);
    ticks_seen = 0;
    repeat (3) begin io.BTN_step = 1'b1; hold(6); io.BTN_step = 1'b0; hold(10); end
    chk("t5_step_ticks", ticks_seen, STEP_ON ? 3 : 0);
    chk("t5_still_paused", int'(io.paused), 1);
    io.BTN_pause = 1'b1; hold(6); io.BTN_pause = 1'b0; hold(8);
    chk("t5_running", int'(io.paused), 0);
    ticks_seen = 0;
    io.BTN_step = 1'b1; hold(6); io.BTN_step = 1'b0; hold(24);
    chk("t5_run_step_ticks", ticks_seen, 3);

    // 6: async reset while paused with dir=1
    io.BTN_pause = 1'b1; hold(6); io.BTN_pause = 1'b0; hold(8);
    hold(3);
    chk("t6_pre_dir", int'(io.dir), 1);
    chk("t6_pre_paused", int'(io.paused), 1);
    #2 RST_n = 1'b0;
    #1;
    chk("t6_async_tick", int'(io.tick), 0);
    chk("t6_async_dir", int'(io.dir), 0);
    chk("t6_async_paused", int'(io.paused), 0);
    model_reset();
    io.SW = 1'b0;
    cyc();
    RST_n = 1'b1;
    run_cadence("t6");

    // Randomized stimulus against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) io.SW = ~io.SW;
      if ($urandom_range(0, 7) == 0) io.BTN_pause = ~io.BTN_pause;
      if ($urandom_range(0, 7) == 0) io.BTN_step = ~io.BTN_step;
      RST_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    RST_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
